// File: rtl/hazard_fwd_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: EX operand forwarding, load-use interlock,
// taken-branch flush and saturating stall/flush performance counters.
module hazard_fwd_unit #(
    parameter int unsigned REG_AW = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic              ex_branch_taken_i,
    input  logic              cnt_clr_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [1:0]       SelRf  = 2'b00;
    localparam logic [1:0]       SelMem = 2'b01;
    localparam logic [1:0]       SelWb  = 2'b10;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic stall_req;

    logic [1:0]       fwd_a_d, fwd_a_q;
    logic [1:0]       fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    // x0 is hard-zero, so a producer targeting it never supplies a value.
    always_comb begin
        ex_hit_a  = id_use_rs1_i && ex_reg_write_i && (ex_rd_i != '0) && (ex_rd_i == id_rs1_i);
        ex_hit_b  = id_use_rs2_i && ex_reg_write_i && (ex_rd_i != '0) && (ex_rd_i == id_rs2_i);
        mem_hit_a = id_use_rs1_i && mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == id_rs1_i);
        mem_hit_b = id_use_rs2_i && mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == id_rs2_i);
    end

    always_comb begin
        if (FWD_EN) begin
            stall_req = ex_mem_read_i && (ex_hit_a || ex_hit_b);
        end else begin
            stall_req = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
        end
    end

    // Taken branch beats a stall: the ID instruction is wrong-path anyway.
    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        if (ex_branch_taken_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else if (stall_req) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end
    end

    function automatic logic [1:0] pick_src(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return SelMem;
        end else if (mem_hit) begin
            return SelWb;
        end
        return SelRf;
    endfunction

    always_comb begin
        fwd_a_d = SelRf;
        fwd_b_d = SelRf;
        if (FWD_EN && !flush_ex_o) begin
            fwd_a_d = pick_src(ex_hit_a, mem_hit_a);
            fwd_b_d = pick_src(ex_hit_b, mem_hit_b);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_id_o && (stall_cnt_q != CntMax)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (ex_branch_taken_i && (flush_cnt_q != CntMax)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_a_q     <= SelRf;
            fwd_b_q     <= SelRf;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a_sel_o = fwd_a_q;
    assign fwd_b_sel_o = fwd_b_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Next-generation hazard controller for the 5-stage RV32I pipeline. It replaces the stall-only detector with EX-stage operand forwarding, one-cycle load-use interlock, taken-branch flush and saturating hazard performance counters. It sits beside the ID/EX pipeline register. Stall and flush outputs are combinational. Forwarding selects are registered so they arrive with the instruction entering EX.

Parameters:
REG_AW, 5, register address width. Register 0 is hard-zero and never matches.
FWD_EN, 1, 1 = forwarding mode; 0 = legacy stall-only mode, where forward selects are always 00.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_AW  ID-stage source 1 address
id_rs2  in  REG_AW  ID-stage source 2 address
id_use_rs1  in  1  ID instruction actually reads rs1
id_use_rs2  in  1  ID instruction actually reads rs2
ex_rd  in  REG_AW  EX-stage destination
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM-stage destination
mem_reg_write  in  1  MEM instruction writes rd
ex_branch_taken  in  1  EX resolved taken branch/jump
cnt_clr  in  1  synchronous clear of counters
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  zero IF/ID register
flush_ex  out  1  load bubble into ID/EX register
fwd_a_sel  out  2  EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
fwd_b_sel  out  2  same encoding, operand B
stall_cnt  out  CNT_W  cycles with stall_id=1
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Source match, per source s: match_ex(s) = use_s && ex_reg_write && ex_rd!=0 && ex_rd==rs_s. match_mem(s) is defined the same way using mem_rd and mem_reg_write.
- Register file is write-first. WB-to-ID needs no handling.
- FWD_EN=1:
  - load_use = ex_mem_read && (match_ex(rs1) || match_ex(rs2)). This is the only stall source.
  - Next forward select per source: match_ex -> 01 (producer will be in MEM); else match_mem -> 10 (producer will be in WB); else 00. EX match has priority over MEM match.
- FWD_EN=0: stall = any match_ex or match_mem on either source. Forward selects are held at 00.
- Stall/flush outputs, in priority order:
  - ex_branch_taken: flush_id=1, flush_ex=1, stall_if=stall_id=0. Branch wins over any simultaneous stall because the ID instruction is wrong-path.
  - Else stall: stall_if=stall_id=1, flush_ex=1.
  - Else all four outputs are 0.
- Forward select registers, updated every rising clk edge:
  - If flush_ex is asserted this cycle (bubble) -> both become 00.
  - Else they load the next values computed above.
- Load-use latency: stall lasts exactly 1 cycle. The following cycle the load is in MEM, match_mem applies, and the select loads 10.
- stall_cnt increments on each cycle with stall_id=1. flush_cnt increments on each cycle with ex_branch_taken=1. Both saturate at all-ones.
- cnt_clr zeroes both counters and has priority over increment in the same cycle.
- Reset (rst_n low, asynchronous): fwd_a_sel=fwd_b_sel=00, stall_cnt=flush_cnt=0. Combinational outputs follow their inputs. Reset mid-stall discards the pending state; there is no replay.

Test Plan:
1. FWD_EN=1. ex: add x5 (ex_reg_write=1, ex_rd=5); ID reads rs1=5. -> No stall; next cycle fwd_a_sel=01, fwd_b_sel=00.
2. FWD_EN=1. EX: load x7 (ex_mem_read=1); ID: rs2=7, use_rs2=1. -> Cycle 0: stall_if=stall_id=flush_ex=1, and at the next edge fwd_b_sel loads 00 (bubble). Cycle 1: producer now in MEM (mem_rd=7); at the following edge fwd_b_sel=10. stall_cnt=1.
3. ex_rd=mem_rd=3, both writing; ID rs1=3. -> fwd_a_sel=01 (EX priority). With rd=0 on all producers, or use_rs1=0 -> fwd_a_sel=00, no stall.
4. Load-use and ex_branch_taken in the same cycle. -> flush_id=flush_ex=1, stall_id=0. flush_cnt+1, stall_cnt unchanged.
5. FWD_EN=0. mem_rd=9 writing; ID rs1=9. -> Stall asserted while the match persists; fwd selects stay 00.
6. CNT_W=2, 5 consecutive stall cycles -> stall_cnt=3 (saturated). cnt_clr during a stall -> 0. Assert rst_n low asynchronously mid-sequence -> selects and counters are 0 immediately.
